dt_param: RTL and testbench

- Parametrised distance-transform engine; successor to the fixed 128x128 chessboard DT block.
- Reads a packed binary image from the sti ROM and unpacks it into the res RAM (one pixel per address).
- Runs a forward raster pass, then a backward raster pass, in place.
- Result: each object pixel holds its distance to the nearest background pixel, in chessboard (8-neighbour) or city-block (4-neighbour) metric, selected per run.

---
 rtl/dt_param.sv | 279 +++++++++++++++++++++++++++
 tb/tb_dt_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_param.sv
// dt_param - parametrised two-pass distance-transform engine.
//
// Unpacks a packed binary image from the sti ROM into the res RAM, one pixel
// per address. Border pixels are forced to 0 while unpacking. A forward raster
// pass and then a backward raster pass run in place over the interior. Each
// object pixel then holds its distance to the nearest background pixel. The
// metric is chessboard (mode=0) or city-block (mode=1).
//
// Optional feature: define DT_MAXDIST_EN to add the max_dist output. It holds
// the largest value written by the backward pass of the last run.
//
// Ports:
//   clk       clock
//   reset     asynchronous, active-low reset
//   start     one-cycle run request, ignored while busy
//   mode      metric select, sampled when start is accepted
//   busy      run in progress (LOAD/FWD/BWD)
//   done      one-cycle end-of-run pulse
//   sti_rd    ROM read enable
//   sti_addr  ROM word address
//   sti_di    ROM data, MSB = leftmost pixel
//   res_rd    RAM read enable
//   res_wr    RAM write enable
//   res_addr  RAM address, row*IMG_W + col
//   res_do    RAM write data
//   res_di    RAM read data
//   max_dist  (DT_MAXDIST_EN only) largest backward-pass write of the last run
module dt_param #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int STI_W  = 16,
    parameter int DIST_W = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 mode,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 sti_rd,
    output logic [$clog2(IMG_W*IMG_H/STI_W)-1:0] sti_addr,
    input  logic [STI_W-1:0]                     sti_di,
    output logic                                 res_rd,
    output logic                                 res_wr,
    output logic [$clog2(IMG_W*IMG_H)-1:0]       res_addr,
    output logic [DIST_W-1:0]                    res_do,
    input  logic [DIST_W-1:0]                    res_di
`ifdef DT_MAXDIST_EN
    ,
    output logic [DIST_W-1:0]                    max_dist
`endif
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int SAW  = $clog2(NPIX / STI_W);
    localparam int KW   = (STI_W > 1) ? $clog2(STI_W) : 1;
    localparam int CW   = $clog2(IMG_W);

    localparam logic [AW-1:0] FIRST_INT = AW'(IMG_W + 1);
    localparam logic [AW-1:0] LAST_INT  = AW'((IMG_H - 2) * IMG_W + IMG_W - 2);
    localparam logic [AW-1:0] LAST_PIX  = AW'(NPIX - 1);
    localparam logic [AW-1:0] BOT_ROW   = AW'((IMG_H - 1) * IMG_W);
    localparam logic [KW-1:0] KLAST     = KW'(STI_W - 1);
    localparam logic [CW-1:0] COL_HI    = CW'(IMG_W - 2);
    localparam logic [CW-1:0] COL_LO    = CW'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FWD, S_BWD, S_FIN} state_e;
    // LOAD: PH_RD issues the ROM read, PH_DATA writes one pixel per cycle.
    // Passes: PH_RD reads p, PH_DATA sees p, PH_NB sees one neighbour per cycle.
    typedef enum logic [1:0] {PH_RD, PH_DATA, PH_NB} phase_e;

    state_e            state, state_nx;
    phase_e            phase, phase_nx;
    logic              mode_r;
    logic [AW-1:0]     addr;
    logic [KW-1:0]     k;
    logic [SAW-1:0]    sti_cnt;
    logic [STI_W-1:0]  shreg;
    logic [DIST_W-1:0] p_val;
    logic [DIST_W-1:0] mn;
    logic [1:0]        nidx;

    logic [CW-1:0]     col;
    logic              border;
    logic              ld_bit;
    logic [1:0]        rd_idx;
    logic [AW-1:0]     nb_mag;
    logic [AW-1:0]     nb_addr;
    logic [DIST_W-1:0] nb_min;
    logic [DIST_W-1:0] nb_inc;
    logic [DIST_W-1:0] wr_val;
    logic              nb_done;
    logic              pass_end;
    logic [AW-1:0]     adv_addr;
    logic              step;

    // IMG_W is a power of two, so the column is the low address bits.
    always_comb begin
        col      = addr[CW-1:0];
        border   = (addr < AW'(IMG_W)) || (addr >= BOT_ROW) ||
                   (col == '0) || (col == '1);
        // The first pixel of a word comes straight from the ROM; the rest
        // come from the shifted copy captured on that cycle.
        ld_bit   = (k == '0) ? sti_di[STI_W-1] : shreg[STI_W-1];
        rd_idx   = (phase == PH_DATA) ? 2'd0 : nidx + 2'd1;
        nb_mag   = AW'(1);
        if (!mode_r) begin
            case (rd_idx)
                2'd0:    nb_mag = AW'(IMG_W + 1);
                2'd1:    nb_mag = AW'(IMG_W);
                2'd2:    nb_mag = AW'(IMG_W - 1);
                default: nb_mag = AW'(1);
            endcase
        end else begin
            nb_mag = (rd_idx == 2'd0) ? AW'(IMG_W) : AW'(1);
        end
        // Neighbours lie before p in the forward pass and after it in the backward pass.
        nb_addr  = (state == S_FWD) ? addr - nb_mag : addr + nb_mag;
        nb_min   = (nidx == 2'd0 || res_di < mn) ? res_di : mn;
        nb_inc   = (&nb_min) ? nb_min : nb_min + DIST_W'(1);
        wr_val   = (state == S_BWD && p_val < nb_inc) ? p_val : nb_inc;
        nb_done  = mode_r ? (nidx == 2'd1) : (nidx == 2'd3);
        pass_end = (state == S_FWD) ? (addr == LAST_INT) : (addr == FIRST_INT);
        if (state == S_FWD)
            adv_addr = (col == COL_HI) ? addr + AW'(3) : addr + AW'(1);
        else
            adv_addr = (col == COL_LO) ? addr - AW'(3) : addr - AW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            phase <= PH_RD;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        busy     = 1'b0;
        done     = 1'b0;
        sti_rd   = 1'b0;
        sti_addr = '0;
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_do   = '0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                    phase_nx = PH_RD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (phase == PH_RD) begin
                    sti_rd   = 1'b1;
                    sti_addr = sti_cnt;
                    phase_nx = PH_DATA;
                end else begin
                    res_wr   = 1'b1;
                    res_addr = addr;
                    res_do   = border ? '0 : DIST_W'(ld_bit);
                    if (k == KLAST) begin
                        phase_nx = PH_RD;
                        if (addr == LAST_PIX)
                            state_nx = S_FWD;
                    end
                end
            end
            S_FWD, S_BWD: begin
                busy = 1'b1;
                case (phase)
                    PH_RD: begin
                        res_rd   = 1'b1;
                        res_addr = addr;
                        phase_nx = PH_DATA;
                    end
                    PH_DATA: begin
                        if (res_di == '0) begin
                            step = 1'b1;
                        end else begin
                            res_rd   = 1'b1;
                            res_addr = nb_addr;
                            phase_nx = PH_NB;
                        end
                    end
                    default: begin
                        if (!nb_done) begin
                            res_rd   = 1'b1;
                            res_addr = nb_addr;
                        end else begin
                            res_wr   = 1'b1;
                            res_addr = addr;
                            res_do   = wr_val;
                            step     = 1'b1;
                        end
                    end
                endcase
                if (step) begin
                    phase_nx = PH_RD;
                    if (pass_end)
                        state_nx = (state == S_FWD) ? S_BWD : S_FIN;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r   <= 1'b0;
            addr     <= '0;
            k        <= '0;
            sti_cnt  <= '0;
            shreg    <= '0;
            p_val    <= '0;
            mn       <= '0;
            nidx     <= '0;
`ifdef DT_MAXDIST_EN
            max_dist <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        addr     <= '0;
                        k        <= '0;
                        sti_cnt  <= '0;
`ifdef DT_MAXDIST_EN
                        max_dist <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (phase == PH_RD) begin
                        sti_cnt <= sti_cnt + SAW'(1);
                    end else begin
                        shreg <= ((k == '0) ? sti_di : shreg) << 1;
                        k     <= (k == KLAST) ? '0 : k + KW'(1);
                        // The last pixel of the image hands over the first forward-pass address.
                        addr  <= (addr == LAST_PIX) ? FIRST_INT : addr + AW'(1);
                    end
                end
                S_FWD, S_BWD: begin
                    if (phase == PH_DATA) begin
                        p_val <= res_di;
                        nidx  <= '0;
                    end
                    if (phase == PH_NB) begin
                        mn <= nb_min;
                        if (!nb_done)
                            nidx <= nidx + 2'd1;
                    end
                    // The forward pass ends on LAST_INT, which is also where the backward pass starts.
                    if (step && !pass_end)
                        addr <= adv_addr;
`ifdef DT_MAXDIST_EN
                    if (state == S_BWD && res_wr && wr_val > max_dist)
                        max_dist <= wr_val;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dt_param.sv
// tb_dt_param - directed self-checking bench for dt_param.
// Two instances: an 8x8 image (8-pixel ROM words, 8-bit distances) and a 16x16
// image with 2-bit distances to exercise saturation. Both share clk and reset.
module tb_dt_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       start, mode, busy, done, sti_rd, res_rd, res_wr;
    logic [2:0] sti_addr;
    logic [7:0] sti_di;
    logic [5:0] res_addr;
    logic [7:0] res_do, res_di;

    logic        start2, mode2, busy2, done2, sti_rd2, res_rd2, res_wr2;
    logic [3:0]  sti_addr2;
    logic [15:0] sti_di2;
    logic [7:0]  res_addr2;
    logic [1:0]  res_do2, res_di2;

`ifdef DT_MAXDIST_EN
    logic [7:0] max_dist;
    logic [1:0] max_dist2;
`endif

    dt_param #(.IMG_W(8), .IMG_H(8), .STI_W(8), .DIST_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .busy(busy), .done(done), .sti_rd(sti_rd), .sti_addr(sti_addr),
        .sti_di(sti_di), .res_rd(res_rd), .res_wr(res_wr),
        .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
`ifdef DT_MAXDIST_EN
        , .max_dist(max_dist)
`endif
    );

    dt_param #(.IMG_W(16), .IMG_H(16), .STI_W(16), .DIST_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2),
        .busy(busy2), .done(done2), .sti_rd(sti_rd2), .sti_addr(sti_addr2),
        .sti_di(sti_di2), .res_rd(res_rd2), .res_wr(res_wr2),
        .res_addr(res_addr2), .res_do(res_do2), .res_di(res_di2)
`ifdef DT_MAXDIST_EN
        , .max_dist(max_dist2)
`endif
    );

    // Synchronous memory models: read data appears the cycle after rd.
    logic [7:0]  rom  [8];
    logic [7:0]  ram  [64];
    logic [15:0] rom2 [16];
    logic [1:0]  ram2 [256];
    logic        fill_req;

    always @(posedge clk) begin
        if (sti_rd)  sti_di  <= rom[sti_addr];
        if (res_rd)  res_di  <= ram[res_addr];
        if (sti_rd2) sti_di2 <= rom2[sti_addr2];
        if (res_rd2) res_di2 <= ram2[res_addr2];
        if (fill_req) begin
            for (int i = 0; i < 64; i++)  ram[i]  <= 8'hA5;
            for (int i = 0; i < 256; i++) ram2[i] <= 2'b10;
        end else begin
            if (res_wr)  ram[res_addr]   <= res_do;
            if (res_wr2) ram2[res_addr2] <= res_do2;
        end
    end

    int n_wr = 0, n_done = 0, n_excl = 0;
    always @(negedge clk) begin
        if (res_wr) n_wr++;
        if (done)   n_done++;
        if ((res_rd && res_wr) || ((res_rd || res_wr) && !busy))     n_excl++;
        if ((res_rd2 && res_wr2) || ((res_rd2 || res_wr2) && !busy2)) n_excl++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_img [8];

    task automatic check_img(input string tag);
        logic [31:0] rowv;
        for (int r = 0; r < 8; r++) begin
            rowv = exp_img[r];
            for (int c = 0; c < 8; c++)
                check_val($sformatf("%s_px%0d%0d", tag, r, c), {24'd0, ram[r*8+c]},
                          {28'd0, rowv[31-4*c -: 4]});
        end
    endtask

    task automatic do_fill();
        @(negedge clk);
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    task automatic start_dt(input int which, input logic m, input string tag);
        @(negedge clk);
        if (which == 0) begin mode = m; start = 1'b1; end
        else begin mode2 = m; start2 = 1'b1; end
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
        check_val({tag, "_busy"}, (which == 0) ? busy : busy2, 1);
    endtask

    task automatic wait_done(input int which, input string tag);
        int t;
        t = 0;
        while (((which == 0) ? done : done2) !== 1'b1 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_done"}, (which == 0) ? done : done2, 1);
    endtask

    task automatic set_rom(input logic [7:0] fill, input logic [7:0] row2);
        for (int i = 0; i < 8; i++) rom[i] = fill;
        rom[2] = row2;
    endtask

    initial begin
        int w0, d0, t, nz, n3;

        reset = 1'b0; start = 1'b0; mode = 1'b0;
        start2 = 1'b0; mode2 = 1'b0; fill_req = 1'b0;
        set_rom(8'hFF, 8'hFF);
        for (int i = 0; i < 16; i++) rom2[i] = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_val("reset_outs",
                  {10'd0, busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do}, 0);
        check_val("reset_outs2",
                  {12'd0, busy2, done2, sti_rd2, res_rd2, res_wr2, sti_addr2, res_addr2, res_do2}, 0);
`ifdef DT_MAXDIST_EN
        check_val("reset_maxd", max_dist, 0);
`endif
        reset = 1'b1;

        // Solid image, chessboard: concentric rings.
        exp_img = '{32'h00000000, 32'h01111110, 32'h01222210, 32'h01233210,
                    32'h01233210, 32'h01222210, 32'h01111110, 32'h00000000};
        do_fill();
        d0 = n_done;
        start_dt(0, 1'b0, "full");
        wait_done(0, "full");
        @(negedge clk);
        check_val("full_busy_after", busy, 0);
        check_val("full_done_cnt", n_done - d0, 1);
        check_img("full");
`ifdef DT_MAXDIST_EN
        check_val("full_maxd", max_dist, 3);
`endif

        // Background pixel at (2,2), chessboard then city-block.
        set_rom(8'hFF, 8'hDF);
        exp_img = '{32'h00000000, 32'h01111110, 32'h01012210, 32'h01112210,
                    32'h01222210, 32'h01222210, 32'h01111110, 32'h00000000};
        do_fill();
        start_dt(0, 1'b0, "hole_cb");
        wait_done(0, "hole_cb");
        check_img("hole_cb");
        exp_img = '{32'h00000000, 32'h01111110, 32'h01012210, 32'h01123210,
                    32'h01233210, 32'h01222210, 32'h01111110, 32'h00000000};
        do_fill();
        start_dt(0, 1'b1, "hole_cty");
        wait_done(0, "hole_cty");
        check_img("hole_cty");

        // All-background image: only the 64 load writes.
        set_rom(8'h00, 8'h00);
        exp_img = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        do_fill();
        w0 = n_wr;
        start_dt(0, 1'b0, "zero");
        wait_done(0, "zero");
        check_val("zero_writes", n_wr - w0, 64);
        check_img("zero");
`ifdef DT_MAXDIST_EN
        check_val("zero_maxd", max_dist, 0);
`endif

        // 2-bit distances on 16x16, city-block: saturate at 3, never wrap.
        start_dt(1, 1'b1, "sat");
        wait_done(1, "sat");
        check_val("sat_c77", ram2[7*16+7], 3);
        check_val("sat_c88", ram2[8*16+8], 3);
        check_val("sat_c33", ram2[3*16+3], 3);
        check_val("sat_c3_12", ram2[3*16+12], 3);
        check_val("sat_c22", ram2[2*16+2], 2);
        check_val("sat_c15", ram2[1*16+5], 1);
        check_val("sat_c13_12", ram2[13*16+12], 2);
        check_val("sat_c14_14", ram2[14*16+14], 1);
        check_val("sat_c00", ram2[0], 0);
        nz = 0;
        n3 = 0;
        for (int r = 1; r < 15; r++)
            for (int c = 1; c < 15; c++) begin
                if (ram2[r*16+c] == 2'd0) nz++;
                if (ram2[r*16+c] == 2'd3) n3++;
            end
        check_val("sat_int_zeros", nz, 0);
        check_val("sat_int_threes", n3, 100);
`ifdef DT_MAXDIST_EN
        check_val("sat_maxd", max_dist2, 3);
`endif

        // Reset during the forward pass, then a clean rerun.
        set_rom(8'hFF, 8'hFF);
        exp_img = '{32'h00000000, 32'h01111110, 32'h01222210, 32'h01233210,
                    32'h01233210, 32'h01222210, 32'h01111110, 32'h00000000};
        do_fill();
        w0 = n_wr;
        start_dt(0, 1'b0, "abort");
        t = 0;
        while (n_wr - w0 < 64 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_val("abort_load_done", (n_wr - w0 >= 64), 1);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("abort_outs_now",
                  {10'd0, busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do}, 0);
        w0 = n_wr;
        @(negedge clk);
        check_val("abort_outs_next",
                  {10'd0, busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do}, 0);
        check_val("abort_no_writes", n_wr - w0, 0);
        reset = 1'b1;
        do_fill();
        start_dt(0, 1'b0, "rerun");
        wait_done(0, "rerun");
        check_img("rerun");

        // start during busy and during FIN is ignored; mid-run mode change has no effect.
        set_rom(8'hFF, 8'hDF);
        exp_img = '{32'h00000000, 32'h01111110, 32'h01012210, 32'h01112210,
                    32'h01222210, 32'h01222210, 32'h01111110, 32'h00000000};
        do_fill();
        d0 = n_done;
        start_dt(0, 1'b0, "ign");
        repeat (20) @(negedge clk);
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, "ign");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("ign_busy_after_fin", busy, 0);
        check_val("ign_done_cnt", n_done - d0, 1);
        check_img("ign");

        check_val("rdwr_excl", n_excl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
